// File: rtl/fb_frame_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// fb_frame_scheduler : clear / draw / vblank-gated swap sequencer
// for a double-buffered frame buffer.                 Revision 1.0
// ------------------------------------------------------------------
module fb_frame_scheduler #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblank,
  input  logic [DATA_W-1:0] bg_color,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_done,
  output logic              rd_ready,
  output logic              frame_start,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              front_sel,
  output logic              swap,
  output logic [7:0]        frame_cnt,
  output logic              oob_err
);

  localparam int                N_PIX      = H_RES * V_RES;
  localparam int                AW1        = ADDR_W + 1;
  // One extra bit so a full 2^ADDR_W frame size is still representable.
  localparam logic [ADDR_W:0]   FRAME_SIZE = AW1'(N_PIX);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_PIX - 1);

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_DRAW    = 2'd1,
    ST_WAIT_VB = 2'd2,
    ST_SWAP    = 2'd3
  } state_t;

  state_t              state_q,       state_d;
  logic [ADDR_W-1:0]   clr_cnt_q,     clr_cnt_d;
  logic [DATA_W-1:0]   bg_q,          bg_d;
  logic                fb_we_q,       fb_we_d;
  logic [ADDR_W-1:0]   fb_addr_q,     fb_addr_d;
  logic [DATA_W-1:0]   fb_data_q,     fb_data_d;
  logic                rd_ready_q,    rd_ready_d;
  logic                frame_start_q, frame_start_d;
  logic                swap_q,        swap_d;
  logic                front_sel_q,   front_sel_d;
  logic [7:0]          frame_cnt_q,   frame_cnt_d;
  logic                oob_err_q,     oob_err_d;

  logic                accept;
  logic                in_range;

  assign accept   = rd_valid & rd_ready_q;
  assign in_range = ({1'b0, rd_addr} < FRAME_SIZE);

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    bg_d          = bg_q;
    fb_we_d       = 1'b0;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    rd_ready_d    = 1'b0;
    frame_start_d = 1'b0;
    swap_d        = 1'b0;
    front_sel_d   = front_sel_q;
    frame_cnt_d   = frame_cnt_q;
    oob_err_d     = oob_err_q;

    case (state_q)
      ST_CLEAR: begin
        fb_we_d   = 1'b1;
        fb_addr_d = clr_cnt_q;
        fb_data_d = bg_q;
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          state_d   = ST_DRAW;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      ST_DRAW: begin
        // First DRAW cycle only raises the grant; frame_start marks that edge.
        rd_ready_d    = 1'b1;
        frame_start_d = ~rd_ready_q;
        if (accept) begin
          if (in_range) begin
            fb_we_d   = 1'b1;
            fb_addr_d = rd_addr;
            fb_data_d = rd_data;
          end else begin
            oob_err_d = 1'b1;
          end
        end
        if (rd_ready_q && rd_done) begin
          rd_ready_d = 1'b0;
          state_d    = ST_WAIT_VB;
        end
      end
      ST_WAIT_VB: begin
        if (vblank) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        swap_d      = 1'b1;
        front_sel_d = ~front_sel_q;
        frame_cnt_d = frame_cnt_q + 8'd1;
        bg_d        = bg_color;
        state_d     = ST_CLEAR;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_CLEAR;
      clr_cnt_q     <= '0;
      bg_q          <= bg_color;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      rd_ready_q    <= 1'b0;
      frame_start_q <= 1'b0;
      swap_q        <= 1'b0;
      front_sel_q   <= 1'b0;
      frame_cnt_q   <= 8'd0;
      oob_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      bg_q          <= bg_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      rd_ready_q    <= rd_ready_d;
      frame_start_q <= frame_start_d;
      swap_q        <= swap_d;
      front_sel_q   <= front_sel_d;
      frame_cnt_q   <= frame_cnt_d;
      oob_err_q     <= oob_err_d;
    end
  end

  assign rd_ready    = rd_ready_q;
  assign frame_start = frame_start_q;
  assign fb_we       = fb_we_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign front_sel   = front_sel_q;
  assign swap        = swap_q;
  assign frame_cnt   = frame_cnt_q;
  assign oob_err     = oob_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_frame_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fb_frame_scheduler : directed scenarios plus randomized run
// against a frame-level reference model.              Revision 1.0
// ------------------------------------------------------------------
module tb_fb_frame_scheduler;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vblank = 1'b0;
  logic [8:0] bg_color = 9'h1FF;
  logic       rd_valid = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic [8:0] rd_data = 9'd0;
  logic       rd_done = 1'b0;
  logic       rd_ready, frame_start, fb_we, front_sel, swap, oob_err;
  logic [3:0] fb_addr;
  logic [8:0] fb_data;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  fb_frame_scheduler #(.H_RES(4), .V_RES(2), .ADDR_W(4), .DATA_W(9)) dut (
    .clk(clk), .rst(rst), .vblank(vblank), .bg_color(bg_color),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
    .rd_ready(rd_ready), .frame_start(frame_start), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .front_sel(front_sel), .swap(swap),
    .frame_cnt(frame_cnt), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  // Reference model: frame phase plus the values each output must carry.
  localparam int M_CLEAR = 0, M_DRAW = 1, M_WAIT = 2, M_SWAP = 3;
  int         m_mode = M_CLEAR;
  int         m_k = 0;
  int         m_cnt = 0;
  logic       m_ready = 1'b0, m_front = 1'b0, m_oob = 1'b0;
  logic [8:0] m_bg = 9'h0;
  logic       e_we = 1'b0, e_fs = 1'b0, e_swap = 1'b0;
  logic [3:0] e_addr = 4'd0;
  logic [8:0] e_data = 9'd0;

  wire [26:0] dut_vec = {rd_ready, frame_start, fb_we, fb_addr, fb_data,
                         front_sel, swap, frame_cnt, oob_err};

  function automatic logic [26:0] exp_vec();
    return {m_ready, e_fs, e_we, e_addr, e_data, m_front, e_swap, 8'(m_cnt), m_oob};
  endfunction

  task automatic model_edge();
    e_we = 1'b0; e_fs = 1'b0; e_swap = 1'b0;
    if (rst) begin
      m_mode = M_CLEAR; m_k = 0; m_bg = bg_color; m_ready = 1'b0;
      m_front = 1'b0; m_cnt = 0; m_oob = 1'b0; e_addr = 4'd0; e_data = 9'd0;
    end else begin
      case (m_mode)
        M_CLEAR: begin
          e_we = 1'b1; e_addr = 4'(m_k); e_data = m_bg;
          if (m_k == N - 1) begin m_k = 0; m_mode = M_DRAW; end
          else m_k = m_k + 1;
        end
        M_DRAW: begin
          if (!m_ready) begin
            m_ready = 1'b1; e_fs = 1'b1;
          end else begin
            if (rd_valid) begin
              if (int'(rd_addr) < N) begin e_we = 1'b1; e_addr = rd_addr; e_data = rd_data; end
              else m_oob = 1'b1;
            end
            if (rd_done) begin m_ready = 1'b0; m_mode = M_WAIT; end
          end
        end
        M_WAIT: if (vblank) m_mode = M_SWAP;
        default: begin
          e_swap = 1'b1; m_front = ~m_front; m_cnt = (m_cnt + 1) % 256;
          m_bg = bg_color; m_mode = M_CLEAR;
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bg_color = 9'h1FF;
    step(); step();
    n_checks++;
    if (dut_vec !== 27'd0) $display("FAIL reset_values got %h want 0", dut_vec);
    else n_pass++;
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      step();
      n_checks++;
      if ({fb_we, fb_addr, fb_data, rd_ready} !== {1'b1, 4'(k), 9'h1FF, 1'b0})
        $display("FAIL clear_write k=%0d got we=%b addr=%0d data=%h rdy=%b want 1/%0d/1ff/0",
                 k, fb_we, fb_addr, fb_data, rd_ready, k);
      else n_pass++;
    end
    step();
    n_checks++;
    if ({rd_ready, frame_start, fb_we} !== 3'b110)
      $display("FAIL draw_entry got rdy/fs/we=%b%b%b want 110", rd_ready, frame_start, fb_we);
    else n_pass++;
    step();
    n_checks++;
    if ({rd_ready, frame_start} !== 2'b10)
      $display("FAIL frame_start_pulse got rdy/fs=%b%b want 10", rd_ready, frame_start);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    rd_valid = 1'b1; rd_addr = 4'd3; rd_data = 9'h038;
    step();
    n_checks++;
    if ({fb_we, fb_addr, fb_data} !== {1'b1, 4'd3, 9'h038})
      $display("FAIL pass_write1 got %b/%0d/%h want 1/3/038", fb_we, fb_addr, fb_data);
    else n_pass++;
    rd_addr = 4'd5; rd_data = 9'h007;
    step();
    n_checks++;
    if ({fb_we, fb_addr, fb_data} !== {1'b1, 4'd5, 9'h007})
      $display("FAIL pass_write2 got %b/%0d/%h want 1/5/007", fb_we, fb_addr, fb_data);
    else n_pass++;
    rd_valid = 1'b0;
    step();
    n_checks++;
    if ({fb_we, oob_err} !== 2'b00)
      $display("FAIL pass_idle got we/oob=%b%b want 00", fb_we, oob_err);
    else n_pass++;
  endtask

  task automatic test_oob();
    rd_valid = 1'b1; rd_addr = 4'd8; rd_data = 9'h155;
    step();
    n_checks++;
    if ({fb_we, oob_err} !== 2'b01)
      $display("FAIL oob_drop got we/oob=%b%b want 01", fb_we, oob_err);
    else n_pass++;
    rd_valid = 1'b0;
    step();
    n_checks++;
    if (oob_err !== 1'b1) $display("FAIL oob_sticky got %b want 1", oob_err);
    else n_pass++;
  endtask

  task automatic test_vblank_gating();
    rd_done = 1'b1;
    step();
    n_checks++;
    if (rd_ready !== 1'b0) $display("FAIL done_ready got %b want 0", rd_ready);
    else n_pass++;
    rd_done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      n_checks++;
      if ({swap, rd_ready, fb_we, front_sel} !== 4'b0000)
        $display("FAIL wait_vb_idle cyc=%0d got swap/rdy/we/front=%b%b%b%b want 0000",
                 i, swap, rd_ready, fb_we, front_sel);
      else n_pass++;
    end
    vblank = 1'b1;
    step();
    n_checks++;
    if (swap !== 1'b0) $display("FAIL swap_early got %b want 0", swap);
    else n_pass++;
    step();
    n_checks++;
    if ({swap, front_sel, frame_cnt, oob_err} !== {1'b1, 1'b1, 8'd1, 1'b1})
      $display("FAIL swap1 got swap=%b front=%b cnt=%0d oob=%b want 1/1/1/1",
               swap, front_sel, frame_cnt, oob_err);
    else n_pass++;
    vblank = 1'b0;
    step();
    n_checks++;
    if ({swap, fb_we, fb_addr} !== {1'b0, 1'b1, 4'd0})
      $display("FAIL clear_restart got swap=%b we=%b addr=%0d want 0/1/0", swap, fb_we, fb_addr);
    else n_pass++;
    for (int i = 0; i < N; i++) step();
    n_checks++;
    if ({frame_start, rd_ready} !== 2'b11)
      $display("FAIL redraw got fs/rdy=%b%b want 11", frame_start, rd_ready);
    else n_pass++;
  endtask

  task automatic test_vblank_high();
    vblank = 1'b1; rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    step();
    n_checks++;
    if ({swap, rd_ready} !== 2'b00) $display("FAIL vbh_pre got swap/rdy=%b%b want 00", swap, rd_ready);
    else n_pass++;
    step();
    n_checks++;
    if ({swap, front_sel, frame_cnt} !== {1'b1, 1'b0, 8'd2})
      $display("FAIL vbh_swap got swap=%b front=%b cnt=%0d want 1/0/2", swap, front_sel, frame_cnt);
    else n_pass++;
    vblank = 1'b0;
    for (int i = 0; i < N + 1; i++) step();
    n_checks++;
    if (frame_start !== 1'b1) $display("FAIL vbh_redraw got fs=%b want 1", frame_start);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    rd_valid = 1'b1; rd_addr = 4'd2; rd_data = 9'h0AA; rd_done = 1'b1;
    step();
    n_checks++;
    if ({rd_ready, fb_we, fb_addr, fb_data} !== {1'b0, 1'b1, 4'd2, 9'h0AA})
      $display("FAIL simul_write got rdy=%b we=%b addr=%0d data=%h want 0/1/2/0aa",
               rd_ready, fb_we, fb_addr, fb_data);
    else n_pass++;
    rd_valid = 1'b0; rd_done = 1'b0;
    step();
    n_checks++;
    if ({rd_ready, fb_we} !== 2'b00) $display("FAIL simul_after got rdy/we=%b%b want 00", rd_ready, fb_we);
    else n_pass++;
    vblank = 1'b1;
    step(); step();
    n_checks++;
    if ({swap, front_sel, frame_cnt} !== {1'b1, 1'b1, 8'd3})
      $display("FAIL simul_swap got swap=%b front=%b cnt=%0d want 1/1/3", swap, front_sel, frame_cnt);
    else n_pass++;
    vblank = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if ({fb_we, fb_addr} !== {1'b1, 4'd4}) $display("FAIL mid_pos got we=%b addr=%0d want 1/4", fb_we, fb_addr);
    else n_pass++;
    rst = 1'b1; bg_color = 9'h055;
    step();
    n_checks++;
    if (dut_vec !== 27'd0) $display("FAIL mid_reset got %h want 0", dut_vec);
    else n_pass++;
    rst = 1'b0;
    step();
    n_checks++;
    if ({fb_we, fb_addr, fb_data} !== {1'b1, 4'd0, 9'h055})
      $display("FAIL mid_restart got %b/%0d/%h want 1/0/055", fb_we, fb_addr, fb_data);
    else n_pass++;
    for (int i = 0; i < N; i++) step();
    rd_done = 1'b1; step(); rd_done = 1'b0;
    vblank = 1'b1; step(); step(); vblank = 1'b0;
    n_checks++;
    if ({swap, front_sel, frame_cnt} !== {1'b1, 1'b1, 8'd1})
      $display("FAIL mid_swap got swap=%b front=%b cnt=%0d want 1/1/1", swap, front_sel, frame_cnt);
    else n_pass++;
    for (int i = 0; i < N + 1; i++) step();
    rd_done = 1'b1; step(); rd_done = 1'b0; step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({front_sel, frame_cnt, rd_ready, fb_we} !== {1'b0, 8'd0, 1'b0, 1'b0})
      $display("FAIL wait_reset got front=%b cnt=%0d rdy=%b we=%b want 0/0/0/0",
               front_sel, frame_cnt, rd_ready, fb_we);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 79) == 0);
      vblank   = ($urandom_range(0, 2) == 0);
      bg_color = 9'($urandom);
      rd_valid = $urandom_range(0, 1) == 1;
      rd_addr  = 4'($urandom_range(0, 11));
      rd_data  = 9'($urandom);
      rd_done  = ($urandom_range(0, 7) == 0);
      step();
      n_checks++;
      if (dut_vec !== exp_vec())
        $display("FAIL random cyc=%0d got %h want %h", i, dut_vec, exp_vec());
      else n_pass++;
    end
    rst = 1'b0; rd_valid = 1'b0; rd_done = 1'b0; vblank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_oob();
    test_vblank_gating();
    test_vblank_high();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
